// File: rtl/alu_divider_if.sv
// Handshake and result bundle between the execute-stage control and the iterative divider.
// The requester drives the master side and the divider drives the slave side.
interface alu_divider_if #(
    parameter int WIDTH = 32
);
    logic             Start;
    logic             Signed;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             Busy;
    logic             Done;
    logic [WIDTH-1:0] Quotient;
    logic [WIDTH-1:0] Remainder;
    logic             DivByZero;
    logic [3:0]       ALUFlags;

    modport master (
        output Start, Signed, A, B,
        input  Busy, Done, Quotient, Remainder, DivByZero, ALUFlags
    );

    modport slave (
        input  Start, Signed, A, B,
        output Busy, Done, Quotient, Remainder, DivByZero, ALUFlags
    );
endinterface

// File: rtl/alu_divider.sv
// Radix-2 restoring divider with a fixed WIDTH+1 cycle busy window for non-zero divisors.
// Works on unsigned magnitudes in CALC and restores the signs in a single FIX cycle.
module alu_divider #(
    parameter int WIDTH = 32
) (
    input  logic         clk,
    input  logic         reset,
    alu_divider_if.slave bus
);
    localparam int CNT_W = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_FIX,
        S_DONE
    } state_t;

    state_t             r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic [WIDTH-1:0]   r_quo;
    logic [WIDTH-1:0]   r_rem;
    logic [WIDTH-1:0]   r_div;
    logic               r_neg_q;
    logic               r_neg_r;
    logic               r_busy;
    logic               r_done;
    logic [WIDTH-1:0]   r_q;
    logic [WIDTH-1:0]   r_r;
    logic               r_dz;

    logic [WIDTH:0]     w_shift;
    logic [WIDTH:0]     w_diff;
    logic               w_ge;
    logic               w_last;

    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v, input logic sgn);
        return (sgn && v[WIDTH-1]) ? -v : v;
    endfunction

    function automatic logic [WIDTH-1:0] cond_neg(input logic [WIDTH-1:0] v, input logic neg);
        return neg ? -v : v;
    endfunction

    // Partial remainder stays below 2*divisor, so the borrow bit alone decides the quotient bit.
    assign w_shift = {r_rem, r_quo[WIDTH-1]};
    assign w_diff  = w_shift - {1'b0, r_div};
    assign w_ge    = ~w_diff[WIDTH];
    assign w_last  = (r_cnt == CNT_W'(WIDTH - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_q     <= '0;
            r_r     <= '0;
            r_dz    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_done <= 1'b0;
                    if (bus.Start) begin
                        if (bus.B == '0) begin
                            r_q     <= '1;
                            r_r     <= bus.A;
                            r_dz    <= 1'b1;
                            r_done  <= 1'b1;
                            r_state <= S_DONE;
                        end else begin
                            r_quo   <= magnitude(bus.A, bus.Signed);
                            r_div   <= magnitude(bus.B, bus.Signed);
                            r_rem   <= '0;
                            r_neg_q <= bus.Signed & (bus.A[WIDTH-1] ^ bus.B[WIDTH-1]);
                            r_neg_r <= bus.Signed & bus.A[WIDTH-1];
                            r_cnt   <= '0;
                            r_busy  <= 1'b1;
                            r_state <= S_CALC;
                        end
                    end
                end
                S_CALC: begin
                    r_rem <= w_ge ? w_diff[WIDTH-1:0] : w_shift[WIDTH-1:0];
                    r_quo <= {r_quo[WIDTH-2:0], w_ge};
                    r_cnt <= r_cnt + CNT_W'(1);
                    if (w_last) begin
                        r_state <= S_FIX;
                    end
                end
                S_FIX: begin
                    r_q     <= cond_neg(r_quo, r_neg_q);
                    r_r     <= cond_neg(r_rem, r_neg_r);
                    r_dz    <= 1'b0;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b1;
                    r_state <= S_DONE;
                end
                S_DONE: begin
                    r_done  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.Busy      = r_busy;
    assign bus.Done      = r_done;
    assign bus.Quotient  = r_q;
    assign bus.Remainder = r_r;
    assign bus.DivByZero = r_dz;
    assign bus.ALUFlags  = {r_q[WIDTH-1], (r_q == '0), 2'b00};
endmodule

// File: tb/tb_alu_divider.sv
// Bench for alu_divider: directed corner cases plus randomized operations scored against an
// arithmetic model built on 64-bit signed division.
module tb_alu_divider;
    localparam int W = 32;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    alu_divider_if #(.WIDTH(W)) bus ();
    alu_divider #(.WIDTH(W)) dut (.clk(clk), .reset(reset), .bus(bus));

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic void model(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                                  output logic [W-1:0] q, output logic [W-1:0] r,
                                  output logic dz);
        longint sa, sb, lq, lr;
        if (b == '0) begin
            q  = '1;
            r  = a;
            dz = 1'b1;
            return;
        end
        sa = s ? longint'($signed(a)) : longint'({32'b0, a});
        sb = s ? longint'($signed(b)) : longint'({32'b0, b});
        lq = sa / sb;
        lr = sa % sb;
        q  = lq[W-1:0];
        r  = lr[W-1:0];
        dz = 1'b0;
    endfunction

    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                          input bit hold, input string tag);
        logic [W-1:0] eq, er;
        logic         edz;
        int           n, busy_n;
        bit           seen;
        model(a, b, s, eq, er, edz);
        bus.A      = a;
        bus.B      = b;
        bus.Signed = s;
        bus.Start  = 1'b1;
        n      = 0;
        busy_n = 0;
        seen   = 0;
        @(negedge clk);
        if (!hold) bus.Start = 1'b0;
        while (n < 100) begin
            n++;
            if (bus.Done) begin
                seen = 1;
                break;
            end
            if (bus.Busy) busy_n++;
            if (hold) begin
                bus.A      = $urandom;
                bus.B      = $urandom;
                bus.Signed = 1'($urandom_range(0, 1));
            end
            @(negedge clk);
        end
        chk({tag, ":done_seen"}, 64'(seen), 64'd1);
        chk({tag, ":latency"}, 64'(n), (b == '0) ? 64'd1 : 64'(W + 2));
        chk({tag, ":busy_cycles"}, 64'(busy_n), (b == '0) ? 64'd0 : 64'(W + 1));
        chk({tag, ":busy_at_done"}, 64'(bus.Busy), 64'd0);
        chk({tag, ":quotient"}, 64'(bus.Quotient), 64'(eq));
        chk({tag, ":remainder"}, 64'(bus.Remainder), 64'(er));
        chk({tag, ":divbyzero"}, 64'(bus.DivByZero), 64'(edz));
        chk({tag, ":flags"}, 64'(bus.ALUFlags), 64'({eq[W-1], (eq == '0), 2'b00}));
        // Start may still be high here; it must be ignored while the pulse is showing.
        @(negedge clk);
        chk({tag, ":done_one_cycle"}, 64'(bus.Done), 64'd0);
        chk({tag, ":no_restart_from_done"}, 64'(bus.Busy), 64'd0);
        chk({tag, ":quotient_held"}, 64'(bus.Quotient), 64'(eq));
        bus.Start = 1'b0;
    endtask

    initial begin
        int done_cnt;
        logic [W-1:0] ra, rb;
        logic rs;

        reset      = 1'b1;
        bus.Start  = 1'b0;
        bus.Signed = 1'b0;
        bus.A      = '0;
        bus.B      = '0;
        repeat (3) @(negedge clk);
        chk("reset:busy", 64'(bus.Busy), 64'd0);
        chk("reset:done", 64'(bus.Done), 64'd0);
        chk("reset:quotient", 64'(bus.Quotient), 64'd0);
        chk("reset:remainder", 64'(bus.Remainder), 64'd0);
        chk("reset:divbyzero", 64'(bus.DivByZero), 64'd0);
        chk("reset:flags", 64'(bus.ALUFlags), 64'h4);
        reset = 1'b0;
        @(negedge clk);

        run_op(32'd100, 32'd7, 1'b0, 0, "t1_udiv");
        run_op(-32'sd100, 32'd7, 1'b1, 0, "t2_neg_pos");
        run_op(32'd100, -32'sd7, 1'b1, 0, "t2_pos_neg");
        run_op(-32'sd100, -32'sd7, 1'b1, 0, "t2_neg_neg");
        run_op(32'h1234, 32'h0, 1'b0, 0, "t3_dz_unsigned");
        run_op(32'h1234, 32'h0, 1'b1, 0, "t3_dz_signed");
        run_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 0, "t4_min_m1_signed");
        run_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 0, "t4_min_m1_unsigned");
        run_op(32'd50, 32'd5, 1'b0, 1, "t6_hold_start");
        run_op(32'd77, 32'd9, 1'b0, 0, "t6_back_to_back");

        // Reset during the 10th CALC cycle discards the operation entirely.
        bus.A      = '1;
        bus.B      = 32'd1;
        bus.Signed = 1'b0;
        bus.Start  = 1'b1;
        @(negedge clk);
        bus.Start = 1'b0;
        repeat (9) @(negedge clk);
        chk("t5:busy_before_reset", 64'(bus.Busy), 64'd1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("t5:busy", 64'(bus.Busy), 64'd0);
        chk("t5:done", 64'(bus.Done), 64'd0);
        chk("t5:quotient", 64'(bus.Quotient), 64'd0);
        chk("t5:remainder", 64'(bus.Remainder), 64'd0);
        done_cnt = 0;
        repeat (40) begin
            @(negedge clk);
            if (bus.Done || bus.Busy) done_cnt++;
        end
        chk("t5:no_activity_after_reset", 64'(done_cnt), 64'd0);
        run_op(32'hFFFF_FFFF, 32'd1, 1'b0, 0, "t5_rerun");

        for (int i = 0; i < 40; i++) begin
            ra = $urandom;
            case ($urandom_range(0, 7))
                0:       rb = '0;
                1:       rb = W'($urandom_range(1, 15));
                2:       rb = '1;
                3:       rb = 32'h8000_0000;
                default: rb = $urandom;
            endcase
            if ($urandom_range(0, 5) == 0) ra = 32'h8000_0000;
            rs = 1'($urandom_range(0, 1));
            run_op(ra, rb, rs, 0, $sformatf("rand%0d", i));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
